// File: rtl/led_anim_scheduler.sv
// LED animation scheduler: debounced start/pause, speed-swap and clear buttons
// drive a three-state run FSM and two interval counters, producing
// one-cycle advance strobes for the outer and inner LED channels.
module led_anim_scheduler #(
    parameter int FAST_PERIOD = 8388608,
    parameter int SLOW_PERIOD = 33554432,
    parameter int DB_CYCLES   = 65536
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_run,
    input  logic       btn_speed,
    input  logic       btn_clear,
    output logic       step_a,
    output logic       step_b,
    output logic       speed,
    output logic       clr,
    output logic [1:0] state
);

    localparam int FW = (FAST_PERIOD > 1) ? $clog2(FAST_PERIOD) : 1;
    localparam int SW = (SLOW_PERIOD > 1) ? $clog2(SLOW_PERIOD) : 1;
    localparam int DW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

    localparam logic [FW-1:0] FAST_LAST = FW'(FAST_PERIOD - 1);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_PERIOD - 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);

    // Button lane indices within the packed button vectors.
    localparam int B_RUN   = 0;
    localparam int B_SPEED = 1;
    localparam int B_CLEAR = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } state_t;

    logic [2:0]    w_btn_raw;
    logic [2:0]    r_sync1;
    logic [2:0]    r_sync2;
    logic [2:0]    r_db_level;
    logic [2:0]    r_db_prev;
    logic [DW-1:0] r_db_cnt [3];
    logic [2:0]    w_press;

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_speed;
    logic          r_clr;
    logic [FW-1:0] r_fast_cnt;
    logic [SW-1:0] r_slow_cnt;
    logic          w_fast_tick;
    logic          w_slow_tick;

    assign w_btn_raw = {btn_clear, btn_speed, btn_run};

    // Press pulse: high for the one cycle after a debounced level rises.
    assign w_press = r_db_level & ~r_db_prev;

    // Two-flop synchronizer for the raw asynchronous buttons.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 3'b000;
            r_sync2 <= 3'b000;
        end else begin
            r_sync1 <= w_btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Debounce: accept a new level after DB_CYCLES consecutive disagreeing cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_db_level <= 3'b000;
            r_db_prev  <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_db_prev <= r_db_level;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] != r_db_level[i]) begin
                    if (r_db_cnt[i] == DB_LAST) begin
                        r_db_level[i] <= r_sync2[i];
                        r_db_cnt[i]   <= '0;
                    end else begin
                        r_db_cnt[i] <= r_db_cnt[i] + DW'(1);
                    end
                end else begin
                    r_db_cnt[i] <= '0;
                end
            end
        end
    end

    // Next-state logic: clear wins over run; run toggles RUN/PAUSE.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_press[B_CLEAR]) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = w_press[B_RUN] ? ST_RUN   : ST_IDLE;
                ST_RUN:   w_state_nxt = w_press[B_RUN] ? ST_PAUSE : ST_RUN;
                ST_PAUSE: w_state_nxt = w_press[B_RUN] ? ST_RUN   : ST_PAUSE;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, speed flag and clear strobe registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_speed <= 1'b0;
            r_clr   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_speed <= r_speed ^ w_press[B_SPEED];
            r_clr   <= w_press[B_CLEAR];
        end
    end

    // Interval counters: run in RUN, hold in PAUSE, zero in IDLE or on a speed swap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fast_cnt <= '0;
            r_slow_cnt <= '0;
        end else if (w_press[B_SPEED]) begin
            r_fast_cnt <= '0;
            r_slow_cnt <= '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_fast_cnt <= (r_fast_cnt == FAST_LAST) ? '0 : r_fast_cnt + FW'(1);
                    r_slow_cnt <= (r_slow_cnt == SLOW_LAST) ? '0 : r_slow_cnt + SW'(1);
                end
                ST_PAUSE: begin
                    r_fast_cnt <= r_fast_cnt;
                    r_slow_cnt <= r_slow_cnt;
                end
                default: begin
                    r_fast_cnt <= '0;
                    r_slow_cnt <= '0;
                end
            endcase
        end
    end

    assign w_fast_tick = (r_state == ST_RUN) && (r_fast_cnt == FAST_LAST);
    assign w_slow_tick = (r_state == ST_RUN) && (r_slow_cnt == SLOW_LAST);

    // The speed flag swaps which interval drives which channel.
    assign step_a = r_speed ? w_slow_tick : w_fast_tick;
    assign step_b = r_speed ? w_fast_tick : w_slow_tick;
    assign speed  = r_speed;
    assign clr    = r_clr;
    assign state  = r_state;

endmodule

// File: tb/tb_led_anim_scheduler.sv
// Scoreboard bench for led_anim_scheduler: a behavioural model predicts the
// outputs after every clock edge into a queue; a monitor on the falling edge
// pops and compares.
module tb_led_anim_scheduler;

    localparam int FAST = 4;
    localparam int SLOW = 16;
    localparam int DB   = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_speed = 1'b0;
    logic       btn_clear = 1'b0;
    logic       step_a;
    logic       step_b;
    logic       speed;
    logic       clr;
    logic [1:0] state;

    int n_tests = 0;
    int n_fail  = 0;

    led_anim_scheduler #(
        .FAST_PERIOD(FAST),
        .SLOW_PERIOD(SLOW),
        .DB_CYCLES  (DB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btn_run),
        .btn_speed(btn_speed),
        .btn_clear(btn_clear),
        .step_a   (step_a),
        .step_b   (step_b),
        .speed    (speed),
        .clr      (clr),
        .state    (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] st;
        logic       spd;
        logic       clr;
        logic       sa;
        logic       sb;
    } exp_t;

    exp_t exp_q[$];

    // Reference model. Modes: 0 idle, 1 running, 2 paused.
    bit [2:0] m_s1, m_s2;   // raw button samples delayed one and two cycles
    bit [2:0] m_db, m_dbd;  // accepted level and its value one cycle earlier
    int       m_cnt[3];     // length of the current disagreement run
    int       m_mode;
    bit       m_spd, m_clr;
    int       m_n;          // running cycles since intervals last restarted

    function automatic exp_t model_outputs();
        exp_t e;
        bit   fast, slow;
        fast   = (m_mode == 1) && ((m_n % FAST) == FAST - 1);
        slow   = (m_mode == 1) && ((m_n % SLOW) == SLOW - 1);
        e.st   = 2'(m_mode);
        e.spd  = m_spd;
        e.clr  = m_clr;
        e.sa   = m_spd ? slow : fast;
        e.sb   = m_spd ? fast : slow;
        return e;
    endfunction

    task automatic model_reset();
        m_s1 = 3'b000; m_s2 = 3'b000; m_db = 3'b000; m_dbd = 3'b000;
        for (int i = 0; i < 3; i++) m_cnt[i] = 0;
        m_mode = 0; m_spd = 1'b0; m_clr = 1'b0; m_n = 0;
    endtask

    task automatic model_step(input bit [2:0] raw);
        bit [2:0] press;
        press = m_db & ~m_dbd;
        if (press[1] || m_mode == 0) m_n = 0;
        else if (m_mode == 1) m_n = m_n + 1;
        if (press[2]) m_mode = 0;
        else if (press[0]) m_mode = (m_mode == 1) ? 2 : 1;
        m_clr = press[2];
        if (press[1]) m_spd = !m_spd;
        m_dbd = m_db;
        for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_db[i]) begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] == DB) begin
                    m_db[i]  = m_s2[i];
                    m_cnt[i] = 0;
                end
            end else begin
                m_cnt[i] = 0;
            end
        end
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    // Predict the post-edge outputs on every rising clock edge.
    always @(posedge clk) begin
        if (rst) model_reset();
        else model_step({btn_clear, btn_speed, btn_run});
        exp_q.push_back(model_outputs());
    end

    // Asynchronous reset: outputs must already be at reset values this cycle.
    always @(posedge rst) begin
        model_reset();
        if (exp_q.size() > 0) begin
            exp_q.delete(exp_q.size() - 1);
            exp_q.push_back(model_outputs());
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge clk) begin
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty t=%0t: no prediction available", $time);
        end else begin
            e = exp_q.pop_front();
            if ({state, speed, clr, step_a, step_b} !== {e.st, e.spd, e.clr, e.sa, e.sb}) begin
                n_fail++;
                $display("FAIL outputs t=%0t got state=%b speed=%b clr=%b step_a=%b step_b=%b want state=%b speed=%b clr=%b step_a=%b step_b=%b",
                         $time, state, speed, clr, step_a, step_b, e.st, e.spd, e.clr, e.sa, e.sb);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input bit [2:0] b, input int hold, input int gap);
        {btn_clear, btn_speed, btn_run} = b;
        cyc(hold);
        {btn_clear, btn_speed, btn_run} = 3'b000;
        cyc(gap);
    endtask

    initial begin
        int r;
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        cyc(3);
        // Start from idle, watch both strobe rates.
        press(3'b001, 10, 40);
        // Short glitch must be ignored.
        press(3'b001, 2, 10);
        // Pause mid-interval, then resume the remaining interval.
        press(3'b001, 6, 21);
        press(3'b001, 6, 30);
        // Speed swap while running.
        press(3'b010, 6, 40);
        // Pause, then run and clear together: clear only.
        press(3'b001, 6, 10);
        press(3'b101, 6, 10);
        // Clear while already idle still strobes clr.
        press(3'b100, 6, 10);
        // Reset in the middle of running.
        press(3'b001, 6, 13);
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        // Button held through reset release counts as a press.
        btn_run = 1'b1;
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(10);
        btn_run = 1'b0;
        cyc(30);
        // Randomized button traffic with occasional resets.
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b0;
            end
            r = $urandom_range(0, 9);
            if (r <= 4) press(3'b001, $urandom_range(1, 6), $urandom_range(0, 25));
            else if (r <= 6) press(3'b010, $urandom_range(1, 6), $urandom_range(0, 25));
            else if (r == 7) press(3'b100, $urandom_range(1, 6), $urandom_range(0, 25));
            else if (r == 8) press(3'($urandom_range(0, 7)), $urandom_range(1, 6), $urandom_range(0, 25));
            else cyc($urandom_range(1, 20));
        end
        cyc(3);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
